// File: rtl/minirisc_pkg.sv
// minirisc_pkg: opcodes, core state encodings, entry fields and sequencer states shared by the mini-RISC sequencer.
package minirisc_pkg;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_HALT  = 3'd7;
    localparam logic [3:0] CS_IDLE  = 4'd0;
    localparam logic [3:0] CS_LOAD  = 4'd1;
    localparam logic [3:0] CS_ADD   = 4'd2;
    localparam logic [3:0] CS_SUB   = 4'd3;
    localparam logic [3:0] CS_STORE = 4'd4;
    localparam int OP_MSB  = 10;
    localparam int OP_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_DONE} seq_state_t;
    function automatic logic is_exec_op(input logic [2:0] op);
        return op >= OP_LOAD && op <= OP_STORE;
    endfunction
endpackage

// File: rtl/minirisc_prog_mem.sv
// minirisc_prog_mem: DEPTH x 11 program register file, synchronous write, asynchronous read, not reset.
module minirisc_prog_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [10:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [10:0]   rdata
);
    logic [10:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/minirisc_sequencer.sv
// minirisc_sequencer: plays a stored program onto the mini-RISC core command bus using its opcode/execute handshake.
module minirisc_sequencer
    import minirisc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [10:0]   prog_wdata,
    input  logic          start,
    input  logic [3:0]    core_state,
    input  logic [7:0]    core_acc,
    output logic [7:0]    cmd_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    store_data,
    output logic          store_valid
);
    seq_state_t state, state_nx;
    logic [AW-1:0] pc, pc_nx;
    logic [10:0] entry;
    logic [2:0] op;
    logic [7:0] imm;
    logic err_set, last, idle_start, capture;
    minirisc_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (prog_we && ena && state == S_IDLE && !start),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (entry)
    );
    assign op = entry[OP_MSB:OP_LSB];
    assign imm = entry[IMM_MSB:IMM_LSB];
    assign last = pc == AW'(DEPTH - 1);
    assign idle_start = ena && state == S_IDLE && start;
    assign capture = ena && state == S_EXEC && op == OP_STORE && !err_set;
    // Only real core opcodes reach the bus; NOP, HALT and illegal entries present an idle command.
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        err_set = 1'b0;
        cmd_out = 8'h00;
        if (!ena) begin
            state_nx = S_IDLE;
            pc_nx = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = start ? S_ISSUE : S_IDLE;
                    pc_nx = '0;
                end
                S_ISSUE: begin
                    cmd_out = is_exec_op(op) ? {5'b0, op} : 8'h00;
                    if (op == OP_NOP) begin
                        state_nx = last ? S_DONE : S_ISSUE;
                        pc_nx = last ? pc : pc + 1'b1;
                    end else if (is_exec_op(op)) begin
                        state_nx = S_EXEC;
                    end else begin
                        err_set = op != OP_HALT;
                        state_nx = S_DONE;
                    end
                end
                S_EXEC: begin
                    cmd_out = op == OP_LOAD ? imm : 8'h00;
                    err_set = core_state != {1'b0, op};
                    state_nx = (err_set || last) ? S_DONE : S_ISSUE;
                    pc_nx = (err_set || last) ? pc : pc + 1'b1;
                end
                S_DONE: state_nx = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            store_data <= 8'h00;
            store_valid <= 1'b0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            busy <= state_nx == S_ISSUE || state_nx == S_EXEC;
            done <= ena && state == S_DONE;
            err <= idle_start ? 1'b0 : err | err_set;
            store_valid <= capture;
            if (capture) store_data <= core_acc;
        end
    end
endmodule

// File: tb/tb_minirisc_sequencer.sv
// tb_minirisc_sequencer: drives programs through the sequencer against a small behavioural core, scoreboarding STORE captures.
module tb_minirisc_sequencer;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, prog_we = 1'b0, start = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [10:0] prog_wdata = '0;
    logic [3:0] core_state, core_st;
    logic [7:0] core_acc, cmd_out, store_data;
    logic busy, done, err, store_valid, force_zero = 1'b0;
    int errors = 0, checks = 0, done_k, done_n;
    logic [7:0] sb[$];
    logic [7:0] trace[$];

    minirisc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .core_state(core_state), .core_acc(core_acc),
        .cmd_out(cmd_out), .busy(busy), .done(done), .err(err),
        .store_data(store_data), .store_valid(store_valid)
    );

    always #5 clk = ~clk;

    // Behavioural core: latches an opcode while idle, executes it on the following cycle.
    assign core_state = force_zero ? 4'd0 : core_st;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !ena) begin
            core_st <= 4'd0;
            core_acc <= 8'h00;
        end else if (core_st == 4'd0) begin
            core_st <= (cmd_out >= 8'd1 && cmd_out <= 8'd4) ? cmd_out[3:0] : 4'd0;
        end else begin
            case (core_st)
                4'd1: core_acc <= cmd_out;
                4'd2: core_acc <= core_acc + 8'd1;
                4'd3: core_acc <= core_acc - 8'd1;
                default: ;
            endcase
            core_st <= 4'd0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && store_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected got %h exp none", store_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (store_data !== e) begin
                    errors++;
                    $display("FAIL store_data got %h exp %h", store_data, e);
                end
            end
        end
    end

    function automatic logic [10:0] ent(input logic [2:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    task automatic wr(input int addr, input logic [10:0] data);
        prog_we = 1'b1;
        prog_addr = AW'(addr);
        prog_wdata = data;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic collect(input int k0, input int kmax);
        trace.delete();
        done_k = -1;
        done_n = 0;
        for (int k = k0; k <= kmax; k++) begin
            @(negedge clk);
            trace.push_back(cmd_out);
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
        end
    endtask

    task automatic check_run(input string name, input int exp_k, input logic exp_err);
        checks++;
        if (done_k !== exp_k || done_n !== 1) begin
            errors++;
            $display("FAIL %s_done got cycle %0d count %0d exp cycle %0d count 1", name, done_k, done_n, exp_k);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s_err got %b exp %b", name, err, exp_err);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_store_missing got %0d pending exp 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({cmd_out, busy, done, err, store_data, store_valid} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got cmd=%h busy=%b done=%b err=%b sd=%h sv=%b exp all zero",
                     cmd_out, busy, done, err, store_data, store_valid);
        end
        rst_n = 1'b1;
        ena = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_cmd [9] = '{8'h01, 8'h10, 8'h02, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00};
        wr(0, ent(3'd1, 8'h10)); wr(1, ent(3'd2, 8'h00)); wr(2, ent(3'd2, 8'h00));
        wr(3, ent(3'd4, 8'h00)); wr(4, ent(3'd7, 8'h00));
        sb.push_back(8'h12);
        start_pulse();
        collect(0, 14);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (trace[i] !== exp_cmd[i]) begin
                errors++;
                $display("FAIL basic_cmd[%0d] got %h exp %h", i, trace[i], exp_cmd[i]);
            end
        end
        check_run("basic", 10, 1'b0);
    endtask

    task automatic test_wrap();
        wr(0, ent(3'd1, 8'h01)); wr(1, ent(3'd3, 8'h00)); wr(2, ent(3'd3, 8'h00));
        wr(3, ent(3'd4, 8'h00)); wr(4, ent(3'd7, 8'h00));
        sb.push_back(8'hFF);
        start_pulse();
        collect(0, 14);
        check_run("wrap_sub", 10, 1'b0);
        wr(0, ent(3'd1, 8'hFF)); wr(1, ent(3'd2, 8'h00)); wr(2, ent(3'd4, 8'h00)); wr(3, ent(3'd7, 8'h00));
        sb.push_back(8'h00);
        start_pulse();
        collect(0, 12);
        check_run("wrap_add", 8, 1'b0);
    endtask

    task automatic test_full();
        wr(0, ent(3'd1, 8'h5A));
        for (int i = 1; i < DEPTH; i++) wr(i, ent(i == DEPTH - 2 ? 3'd4 : 3'd0, 8'h00));
        sb.push_back(8'h5A);
        start_pulse();
        collect(0, 16);
        check_run("full", 11, 1'b0);
        checks++;
        if (cmd_out !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_idle got cmd=%h busy=%b exp cmd=00 busy=0", cmd_out, busy);
        end
    endtask

    task automatic test_illegal();
        logic bad;
        wr(0, ent(3'd1, 8'h33)); wr(1, ent(3'd5, 8'h00)); wr(2, ent(3'd4, 8'h00)); wr(3, ent(3'd7, 8'h00));
        start_pulse();
        collect(0, 8);
        check_run("illegal", 4, 1'b1);
        bad = 1'b0;
        for (int k = 2; k <= 8; k++) bad |= trace[k] != 8'h00;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL illegal_quiet got cmd activity after illegal op exp all 00");
        end
        wr(0, ent(3'd1, 8'h44)); wr(1, ent(3'd4, 8'h00)); wr(2, ent(3'd7, 8'h00));
        force_zero = 1'b1;
        start_pulse();
        collect(0, 8);
        check_run("mismatch", 3, 1'b1);
        force_zero = 1'b0;
        sb.push_back(8'h44);
        start_pulse();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b busy=%b exp err=0 busy=1", err, busy);
        end
        collect(1, 10);
        check_run("rerun", 6, 1'b0);
    endtask

    task automatic test_abort();
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_out !== 8'h00 || done !== 1'b0 || store_data !== 8'h44) begin
            errors++;
            $display("FAIL abort_ena got busy=%b cmd=%h done=%b sd=%h exp busy=0 cmd=00 done=0 sd=44",
                     busy, cmd_out, done, store_data);
        end
        collect(3, 8);
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses exp 0", done_n);
        end
        ena = 1'b1;
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_out, busy, done, err, store_data, store_valid} !== 20'h0) begin
            errors++;
            $display("FAIL abort_rst got cmd=%h busy=%b done=%b err=%b sd=%h sv=%b exp all zero",
                     cmd_out, busy, done, err, store_data, store_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        wr(0, ent(3'd1, 8'h07)); wr(1, ent(3'd2, 8'h00)); wr(2, ent(3'd4, 8'h00)); wr(3, ent(3'd7, 8'h00));
        sb.push_back(8'h08);
        start_pulse();
        @(negedge clk);
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = '0;
        prog_wdata = ent(3'd1, 8'h99);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
        collect(3, 14);
        check_run("guard", 8, 1'b0);
        sb.push_back(8'h08);
        start_pulse();
        collect(0, 12);
        check_run("guard_rerun", 8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_illegal();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
